// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate data cache with a 128-bit block port.
// Optional hit/miss/writeback counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_direct_mapped #(
    parameter int NUM_BLOCKS = 8,
    parameter int TAG_W      = 28 - $clog2(NUM_BLOCKS)
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses,
    output logic [31:0]  perf_writebacks
`endif
);

    localparam int IW = $clog2(NUM_BLOCKS);

    localparam logic [1:0] COMPARE   = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    logic [IW-1:0]    idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    logic [127:0]     line;
    logic [31:0]      word;
    logic             req;
    logic             hit;
    logic             wr_hit;
    logic             fill;
    logic             wb_done;

    assign idx  = proc_addr[IW+1:2];
    assign tag  = proc_addr[29:IW+2];
    assign off  = proc_addr[1:0];
    assign line = data_q[idx];
    assign word = line[{off, 5'b0} +: 32];
    assign req  = proc_read | proc_write;
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d    = state_q;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 28'd0;
        mem_wdata  = 128'd0;
        wr_hit     = 1'b0;
        fill       = 1'b0;
        wb_done    = 1'b0;
        case (state_q)
            COMPARE: begin
                if (hit) proc_rdata = word;
                if (req && !hit) begin
                    proc_stall = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end else if (proc_write) begin
                    wr_hit = 1'b1;
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
                mem_wdata  = line;
                if (mem_ready) begin
                    wb_done = 1'b1;
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[29:2];
                if (mem_ready) begin
                    fill    = 1'b1;
                    state_d = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= COMPARE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (wr_hit) dirty_q[idx] <= 1'b1;
            if (wb_done) dirty_q[idx] <= 1'b0;
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_hit) data_q[idx][{off, 5'b0} +: 32] <= proc_wdata;
        if (fill) begin
            data_q[idx] <= mem_rdata;
            tag_q[idx]  <= tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic [31:0] wbs_q;
    logic        miss_q;
    logic        is_cmp;

    assign is_cmp = (state_q == COMPARE);

    // miss_q marks a request already counted as a miss, so its replay hit is skipped.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hits_q   <= 32'd0;
            misses_q <= 32'd0;
            wbs_q    <= 32'd0;
            miss_q   <= 1'b0;
        end else begin
            if (is_cmp && req && hit && !miss_q && hits_q != 32'hFFFF_FFFF)
                hits_q <= hits_q + 32'd1;
            if (is_cmp && req && !hit && misses_q != 32'hFFFF_FFFF)
                misses_q <= misses_q + 32'd1;
            if (wb_done && wbs_q != 32'hFFFF_FFFF)
                wbs_q <= wbs_q + 32'd1;
            if (is_cmp && req && !hit)
                miss_q <= 1'b1;
            else if (is_cmp && req && hit)
                miss_q <= 1'b0;
        end
    end

    assign perf_hits       = hits_q;
    assign perf_misses     = misses_q;
    assign perf_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped.
// Builds with or without DCACHE_PERF_CNT_EN.
module tb_dcache_direct_mapped;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic [127:0] mem_wdata;
    logic         mem_ready;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;
    logic [31:0]  perf_writebacks;
`endif

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] BLK1 = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] BLK2 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BLK3 = 128'hC0C0C0C0_B0B0B0B0_A0A0A0A0_90909090;
    localparam logic [127:0] BLK4 = 128'h0F0F0F0F_0E0E0E0E_0D0D0D0D_0C0C0C0C;

    always #5 clk = ~clk;

    dcache_direct_mapped dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory responder: pulses mem_ready on the lat-th cycle of each phase.
    // Returns at the negedge of the first cycle with proc_stall low.
    task automatic serve(input int lat, input logic [127:0] blk,
                         output int stall_n, output bit saw_wr,
                         output logic [27:0] wr_addr, output logic [127:0] wr_data,
                         output logic [27:0] rd_addr, output bit both, output bit tmo);
        int wc;
        int rc;
        wc = 0; rc = 0; stall_n = 0; saw_wr = 0; both = 0; tmo = 1;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!proc_stall) begin
                tmo = 0;
                break;
            end
            stall_n++;
            if (mem_read && mem_write) both = 1;
            if (mem_write) begin
                saw_wr = 1; wr_addr = mem_addr; wr_data = mem_wdata;
                wc++;
                if (wc == lat) mem_ready = 1'b1;
            end
            if (mem_read) begin
                rd_addr = mem_addr;
                rc++;
                if (rc == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = blk;
                end
            end
            tick;
            mem_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick; tick;
        proc_reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (proc_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", proc_stall); end
        n_vec++;
        if (proc_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", proc_rdata); end
        n_vec++;
        if ({mem_read, mem_write} !== 2'b00) begin n_err++; $display("FAIL rst_mem_rw: got %b want 00", {mem_read, mem_write}); end
        n_vec++;
        if (mem_addr !== 28'd0 || mem_wdata !== 128'd0) begin n_err++; $display("FAIL rst_mem_bus: addr %h wdata %h want 0", mem_addr, mem_wdata); end
`ifdef DCACHE_PERF_CNT_EN
        n_vec++;
        if ({perf_hits, perf_misses, perf_writebacks} !== 96'd0) begin n_err++; $display("FAIL rst_perf: got %h want 0", {perf_hits, perf_misses, perf_writebacks}); end
`endif
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({proc_stall, mem_read, mem_write} !== 3'b000) begin n_err++; $display("FAIL ready_in_compare: got %b want 000", {proc_stall, mem_read, mem_write}); end
        tick;
    endtask

    task automatic test_cold_read_miss;
        int sn; bit sw, bo, to; logic [27:0] wa, ra; logic [127:0] wd;
        proc_read = 1'b1; proc_addr = 30'h0000_0005;
        serve(4, BLK1, sn, sw, wa, wd, ra, bo, to);
        n_vec++;
        if (to !== 1'b0 || sn !== 5) begin n_err++; $display("FAIL cold_stall_len: got %0d (timeout %b) want 5", sn, to); end
        n_vec++;
        if (ra !== 28'h1 || sw !== 1'b0) begin n_err++; $display("FAIL cold_alloc: addr %h wr %b want 1/0", ra, sw); end
        n_vec++;
        if (proc_rdata !== 32'hB) begin n_err++; $display("FAIL cold_rdata: got %h want 0000000b", proc_rdata); end
        tick;
    endtask

    task automatic test_read_hit;
        proc_read = 1'b1; proc_addr = 30'h4;
        @(negedge clk);
        n_vec++;
        if (proc_stall !== 1'b0 || mem_read !== 1'b0) begin n_err++; $display("FAIL hit_stall: stall %b mem_read %b want 0/0", proc_stall, mem_read); end
        n_vec++;
        if (proc_rdata !== 32'hA) begin n_err++; $display("FAIL hit_rdata: got %h want 0000000a", proc_rdata); end
        tick;
    endtask

    task automatic test_dirty_evict;
        int sn; bit sw, bo, to; logic [27:0] wa, ra; logic [127:0] wd;
        proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h4; proc_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_vec++;
        if (proc_stall !== 1'b0) begin n_err++; $display("FAIL wr_hit_stall: got %b want 0", proc_stall); end
        tick;
        proc_write = 1'b0; proc_read = 1'b1; proc_addr = 30'h24;
        serve(2, BLK2, sn, sw, wa, wd, ra, bo, to);
        n_vec++;
        if (sw !== 1'b1 || wa !== 28'h1) begin n_err++; $display("FAIL evict_wb: wr %b addr %h want 1/0000001", sw, wa); end
        n_vec++;
        if (wd[63:0] !== 64'h0000000B_DEADBEEF) begin n_err++; $display("FAIL evict_wdata: got %h want 0000000bdeadbeef", wd[63:0]); end
        n_vec++;
        if (ra !== 28'h9 || bo !== 1'b0) begin n_err++; $display("FAIL evict_alloc: addr %h both %b want 0000009/0", ra, bo); end
        n_vec++;
        if (to !== 1'b0 || sn !== 5) begin n_err++; $display("FAIL evict_stall_len: got %0d (timeout %b) want 5", sn, to); end
        n_vec++;
        if (proc_rdata !== 32'h11111111) begin n_err++; $display("FAIL evict_rdata: got %h want 11111111", proc_rdata); end
        tick;
    endtask

    task automatic test_write_miss_clean;
        int sn; bit sw, bo, to; logic [27:0] wa, ra; logic [127:0] wd;
        proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h0; proc_wdata = 32'h1234;
        serve(3, BLK3, sn, sw, wa, wd, ra, bo, to);
        n_vec++;
        if (sw !== 1'b0 || ra !== 28'h0) begin n_err++; $display("FAIL wmiss_phases: wr %b addr %h want 0/0", sw, ra); end
        n_vec++;
        if (to !== 1'b0 || sn !== 4) begin n_err++; $display("FAIL wmiss_stall_len: got %0d (timeout %b) want 4", sn, to); end
`ifdef DCACHE_PERF_CNT_EN
        n_vec++;
        if (perf_misses !== 32'd3 || perf_hits !== 32'd2 || perf_writebacks !== 32'd1)
            begin n_err++; $display("FAIL perf_counts: h %0d m %0d wb %0d want 2/3/1", perf_hits, perf_misses, perf_writebacks); end
`endif
        tick;
        proc_write = 1'b0; proc_read = 1'b1;
        @(negedge clk);
        n_vec++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h1234) begin n_err++; $display("FAIL wmiss_merge: stall %b rdata %h want 0/00001234", proc_stall, proc_rdata); end
        tick;
        proc_addr = 30'h1;
        @(negedge clk);
        n_vec++;
        if (proc_rdata !== 32'hA0A0A0A0) begin n_err++; $display("FAIL wmiss_other_word: got %h want a0a0a0a0", proc_rdata); end
        tick;
    endtask

    task automatic test_rw_both;
        proc_read = 1'b1; proc_write = 1'b1; proc_addr = 30'h0; proc_wdata = 32'h55;
        @(negedge clk);
        n_vec++;
        if (proc_stall !== 1'b0 || proc_rdata !== 32'h1234) begin n_err++; $display("FAIL rw_both: stall %b rdata %h want 0/00001234", proc_stall, proc_rdata); end
        tick;
        proc_write = 1'b0;
        @(negedge clk);
        n_vec++;
        if (proc_rdata !== 32'h55) begin n_err++; $display("FAIL rw_both_write: got %h want 00000055", proc_rdata); end
        tick;
    endtask

    task automatic test_reset_mid_alloc;
        int sn; bit sw, bo, to; logic [27:0] wa, ra; logic [127:0] wd;
        bit seen;
        seen = 0;
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h44;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_read) begin seen = 1; break; end
            tick;
        end
        n_vec++;
        if (seen !== 1'b1) begin n_err++; $display("FAIL midrst_alloc_seen: got %b want 1", seen); end
        proc_reset = 1'b1;
        tick;
        proc_reset = 1'b0; proc_read = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_read, proc_stall} !== 2'b00) begin n_err++; $display("FAIL midrst_drop: got %b want 00", {mem_read, proc_stall}); end
`ifdef DCACHE_PERF_CNT_EN
        n_vec++;
        if ({perf_hits, perf_misses, perf_writebacks} !== 96'd0) begin n_err++; $display("FAIL midrst_perf: got %h want 0", {perf_hits, perf_misses, perf_writebacks}); end
`endif
        tick;
        proc_read = 1'b1; proc_addr = 30'h0;
        @(negedge clk);
        n_vec++;
        if (proc_stall !== 1'b1) begin n_err++; $display("FAIL midrst_remiss: stall %b want 1", proc_stall); end
        tick;
        serve(1, BLK4, sn, sw, wa, wd, ra, bo, to);
        n_vec++;
        if (to !== 1'b0 || sw !== 1'b0 || ra !== 28'h0) begin n_err++; $display("FAIL midrst_refill: tmo %b wr %b addr %h want 0/0/0", to, sw, ra); end
        n_vec++;
        if (proc_rdata !== 32'h0C0C0C0C) begin n_err++; $display("FAIL midrst_rdata: got %h want 0c0c0c0c", proc_rdata); end
        tick;
        proc_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_cold_read_miss;
        test_read_hit;
        test_dirty_evict;
        test_write_miss_clean;
        test_rw_both;
        test_reset_mid_alloc;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
